// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm bank: FSM states, BCD digit limits and
// the width of the minute counters.
package aclk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } state_e;

    // Largest legal value of each BCD digit position
    localparam logic [3:0] BCD_MS_HR_MAX    = 4'd2;
    localparam logic [3:0] BCD_LS_HR_MAX_20 = 4'd3;  // ls_hr limit when ms_hr == 2
    localparam logic [3:0] BCD_MS_MIN_MAX   = 4'd5;
    localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;

    // Snooze and ring-timeout counters; both limits are capped at 63
    localparam int CNT_W = 6;

endpackage

// File: rtl/aclk_bcd_time_valid.sv
// Combinational check that four BCD digits form a legal 24-hour HH:MM time.
module aclk_bcd_time_valid
    import aclk_pkg::*;
(
    input  logic [3:0] ms_hr,
    input  logic [3:0] ls_hr,
    input  logic [3:0] ms_min,
    input  logic [3:0] ls_min,
    output logic       valid
);

    // Per-digit range checks, then the 20..23 hour restriction
    always_comb begin
        valid = (ms_hr  <= BCD_MS_HR_MAX)  && (ls_hr  <= BCD_DIGIT_MAX) &&
                (ms_min <= BCD_MS_MIN_MAX) && (ls_min <= BCD_DIGIT_MAX);
        if ((ms_hr == BCD_MS_HR_MAX) && (ls_hr > BCD_LS_HR_MAX_20)) begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/aclk_alarm_bank.sv
// Multi-slot BCD alarm store with per-slot enable, registered read port,
// minute-tick matching and a ring / snooze / auto-off state machine.
module aclk_alarm_bank
    import aclk_pkg::*;
#(
    parameter int NUM_ALARMS   = 4,
    parameter int IDX_W        = 2,
    parameter int SNOOZE_MIN   = 9,
    parameter int RING_MAX_MIN = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_new_a,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [3:0]       new_alarm_ms_hr,
    input  logic [3:0]       new_alarm_ls_hr,
    input  logic [3:0]       new_alarm_ms_min,
    input  logic [3:0]       new_alarm_ls_min,
    input  logic             new_alarm_en,
    output logic             load_err,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [3:0]       alarm_time_ms_hr,
    output logic [3:0]       alarm_time_ls_hr,
    output logic [3:0]       alarm_time_ms_min,
    output logic [3:0]       alarm_time_ls_min,
    output logic             alarm_en,
    input  logic [3:0]       current_time_ms_hr,
    input  logic [3:0]       current_time_ls_hr,
    input  logic [3:0]       current_time_ms_min,
    input  logic [3:0]       current_time_ls_min,
    input  logic             minute_tick,
    input  logic             snooze,
    input  logic             alarm_off,
    output logic             alarm_ring,
    output logic [IDX_W-1:0] ring_idx
);

    logic [15:0]           slot_time_q [NUM_ALARMS];
    logic [15:0]           slot_time_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] slot_en_q, slot_en_d;
    logic                  load_err_q, load_err_d;
    logic [15:0]           rd_time_q, rd_time_d;
    logic                  rd_en_q, rd_en_d;
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      ring_cnt_q, ring_cnt_d;
    logic [CNT_W-1:0]      snz_cnt_q, snz_cnt_d;
    logic [IDX_W-1:0]      ring_idx_q, ring_idx_d;
    logic                  alarm_ring_q, alarm_ring_d;

    logic                  digits_ok;
    logic                  load_ok;
    logic [15:0]           new_time;
    logic [15:0]           cur_time;
    logic                  match_hit;
    logic [IDX_W-1:0]      match_idx;

    assign new_time = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
    assign cur_time = {current_time_ms_hr, current_time_ls_hr,
                       current_time_ms_min, current_time_ls_min};

    aclk_bcd_time_valid u_load_valid (
        .ms_hr  (new_alarm_ms_hr),
        .ls_hr  (new_alarm_ls_hr),
        .ms_min (new_alarm_ms_min),
        .ls_min (new_alarm_ls_min),
        .valid  (digits_ok)
    );

    assign load_ok = digits_ok && (32'(load_idx) < 32'(NUM_ALARMS));

    // Slot write on a valid load; a rejected load only raises load_err
    always_comb begin
        slot_time_d = slot_time_q;
        slot_en_d   = slot_en_q;
        load_err_d  = load_new_a && !load_ok;
        if (load_new_a && load_ok) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (load_idx == IDX_W'(i)) begin
                    slot_time_d[i] = new_time;
                    slot_en_d[i]   = new_alarm_en;
                end
            end
        end
    end

    // Display read mux; an index beyond the bank reads as 00:00 disabled
    always_comb begin
        rd_time_d = '0;
        rd_en_d   = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_time_d = slot_time_q[i];
                rd_en_d   = slot_en_q[i];
            end
        end
    end

    // Enabled slots equal to the current time; scanning downward leaves the lowest index
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_en_q[i] && (slot_time_q[i] == cur_time)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    // Ring FSM: alarm_off beats snooze beats minute_tick. Snooze while already
    // snoozed has no effect, so a tick in that cycle still counts down.
    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snz_cnt_d    = snz_cnt_q;
        ring_idx_d   = ring_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (minute_tick && match_hit) begin
                    state_d    = ST_RINGING;
                    ring_idx_d = match_idx;
                    ring_cnt_d = '0;
                end
            end
            ST_RINGING: begin
                if (alarm_off) begin
                    state_d = ST_IDLE;
                end else if (snooze) begin
                    state_d   = ST_SNOOZED;
                    snz_cnt_d = CNT_W'(SNOOZE_MIN);
                end else if (minute_tick) begin
                    ring_cnt_d = ring_cnt_q + CNT_W'(1);
                    if (ring_cnt_d == CNT_W'(RING_MAX_MIN)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SNOOZED: begin
                if (alarm_off) begin
                    state_d = ST_IDLE;
                end else if (minute_tick) begin
                    if (snz_cnt_q == CNT_W'(1)) begin
                        state_d    = ST_RINGING;
                        ring_cnt_d = '0;
                        snz_cnt_d  = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        alarm_ring_d = (state_d == ST_RINGING);
    end

    // Slot storage and load error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_time_q[i] <= '0;
            end
            slot_en_q  <= '0;
            load_err_q <= 1'b0;
        end else begin
            slot_time_q <= slot_time_d;
            slot_en_q   <= slot_en_d;
            load_err_q  <= load_err_d;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_time_q <= '0;
            rd_en_q   <= 1'b0;
        end else begin
            rd_time_q <= rd_time_d;
            rd_en_q   <= rd_en_d;
        end
    end

    // FSM state, counters and ring outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ring_cnt_q   <= '0;
            snz_cnt_q    <= '0;
            ring_idx_q   <= '0;
            alarm_ring_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            ring_idx_q   <= ring_idx_d;
            alarm_ring_q <= alarm_ring_d;
        end
    end

    assign load_err = load_err_q;
    assign {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min} = rd_time_q;
    assign alarm_en   = rd_en_q;
    assign alarm_ring = alarm_ring_q;
    assign ring_idx   = ring_idx_q;

endmodule
